// File: rtl/entity_coord_scheduler.sv
`timescale 1ns/1ps
// Per-frame scheduler sharing one polar->screen converter across entity slots.
// Define SHADOW_TABLE_EN for a double-buffered table swapped at end of scan.
module entity_coord_scheduler #(
   parameter int N_ENT    = 8,
   parameter int IDX_W    = 3,
   parameter int LAT      = 1,
   parameter int V_ACTIVE = 480
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [9:0]       hc,
   input  logic [9:0]       vc,
   output logic [IDX_W-1:0] polar_idx,
   input  logic [8:0]       polar_distance,
   input  logic [3:0]       polar_angle,
   input  logic             polar_alive,
   output logic [8:0]       cv_distance,
   output logic [3:0]       cv_angle,
   input  logic [9:0]       cv_x,
   input  logic [9:0]       cv_y,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [9:0]       rd_x,
   output logic [9:0]       rd_y,
   output logic             rd_alive,
   output logic             busy,
   output logic             done,
   output logic             overrun
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_STORE
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [IDX_W-1:0] slot;
   logic [IDX_W-1:0] slot_nxt;
   logic [2:0]       wcnt;
   logic [2:0]       wcnt_nxt;
   logic             trig;
   logic             ld_cv;
   logic             wr;
   logic             wr_live;
   logic             adv;
   logic             last;

   assign trig      = (hc == 10'd0) && (vc == 10'(V_ACTIVE));
   assign busy      = (state != S_IDLE);
   assign polar_idx = slot;

   always_comb begin
      state_nxt = state;
      slot_nxt  = slot;
      wcnt_nxt  = wcnt;
      ld_cv     = 1'b0;
      wr        = 1'b0;
      wr_live   = 1'b0;
      adv       = 1'b0;
      last      = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (trig) begin
               slot_nxt  = '0;
               state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (polar_alive) begin
               ld_cv     = 1'b1;
               wcnt_nxt  = '0;
               state_nxt = S_WAIT;
            end else begin
               wr  = 1'b1;
               adv = 1'b1;
            end
         end
         S_WAIT: begin
            if (wcnt == 3'(LAT - 1)) state_nxt = S_STORE;
            else wcnt_nxt = wcnt + 3'd1;
         end
         S_STORE: begin
            wr      = 1'b1;
            wr_live = 1'b1;
            adv     = 1'b1;
         end
         default: state_nxt = S_IDLE;
      endcase
      // slot advance folds into the same edge as the table write
      if (adv) begin
         if (slot == IDX_W'(N_ENT - 1)) begin
            last      = 1'b1;
            state_nxt = S_IDLE;
         end else begin
            slot_nxt  = slot + IDX_W'(1);
            state_nxt = S_ISSUE;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state       <= S_IDLE;
         slot        <= '0;
         wcnt        <= '0;
         cv_distance <= '0;
         cv_angle    <= '0;
         done        <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         state   <= state_nxt;
         slot    <= slot_nxt;
         wcnt    <= wcnt_nxt;
         done    <= last;
         overrun <= trig && (state != S_IDLE);
         if (ld_cv) begin
            cv_distance <= polar_distance;
            cv_angle    <= polar_angle;
         end
      end
   end

`ifdef SHADOW_TABLE_EN
   logic [9:0]       tx [2][N_ENT];
   logic [9:0]       ty [2][N_ENT];
   logic [N_ENT-1:0] ta [2];
   logic             front;
   logic             back;

   assign back = ~front;

   always_ff @(posedge CLK) begin
      if (RST) begin
         front <= 1'b0;
         for (int b = 0; b < 2; b++) begin
            ta[b] <= '0;
            for (int i = 0; i < N_ENT; i++) begin
               tx[b][i] <= '0;
               ty[b][i] <= '0;
            end
         end
      end else begin
         if (wr) begin
            ta[back][slot] <= wr_live;
            if (wr_live) begin
               tx[back][slot] <= cv_x;
               ty[back][slot] <= cv_y;
            end
         end
         if (last) front <= back;
      end
   end

   assign rd_x     = tx[front][rd_idx];
   assign rd_y     = ty[front][rd_idx];
   assign rd_alive = ta[front][rd_idx];
`else
   logic [9:0]       tx [N_ENT];
   logic [9:0]       ty [N_ENT];
   logic [N_ENT-1:0] ta;

   always_ff @(posedge CLK) begin
      if (RST) begin
         ta <= '0;
         for (int i = 0; i < N_ENT; i++) begin
            tx[i] <= '0;
            ty[i] <= '0;
         end
      end else if (wr) begin
         ta[slot] <= wr_live;
         if (wr_live) begin
            tx[slot] <= cv_x;
            ty[slot] <= cv_y;
         end
      end
   end

   assign rd_x     = tx[rd_idx];
   assign rd_y     = ty[rd_idx];
   assign rd_alive = ta[rd_idx];
`endif

endmodule

// File: tb/tb_entity_coord_scheduler.sv
`timescale 1ns/1ps
// Scoreboard bench for entity_coord_scheduler with a frame-level table model.
module tb_entity_coord_scheduler;

   localparam int N_ENT    = 8;
   localparam int IDX_W    = 3;
   localparam int LAT      = 1;
   localparam int V_ACTIVE = 480;
`ifdef SHADOW_TABLE_EN
   localparam bit SHADOW = 1'b1;
`else
   localparam bit SHADOW = 1'b0;
`endif

   logic             CLK = 1'b0;
   logic             RST = 1'b1;
   logic [9:0]       hc = 10'd1;
   logic [9:0]       vc = 10'd0;
   logic [IDX_W-1:0] polar_idx;
   logic [8:0]       polar_distance;
   logic [3:0]       polar_angle;
   logic             polar_alive;
   logic [8:0]       cv_distance;
   logic [3:0]       cv_angle;
   logic [9:0]       cv_x;
   logic [9:0]       cv_y;
   logic [IDX_W-1:0] rd_idx;
   logic [9:0]       rd_x;
   logic [9:0]       rd_y;
   logic             rd_alive;
   logic             busy;
   logic             done;
   logic             overrun;

   entity_coord_scheduler #(
      .N_ENT(N_ENT), .IDX_W(IDX_W), .LAT(LAT), .V_ACTIVE(V_ACTIVE)
   ) dut (
      .CLK(CLK), .RST(RST), .hc(hc), .vc(vc),
      .polar_idx(polar_idx), .polar_distance(polar_distance),
      .polar_angle(polar_angle), .polar_alive(polar_alive),
      .cv_distance(cv_distance), .cv_angle(cv_angle),
      .cv_x(cv_x), .cv_y(cv_y),
      .rd_idx(rd_idx), .rd_x(rd_x), .rd_y(rd_y), .rd_alive(rd_alive),
      .busy(busy), .done(done), .overrun(overrun)
   );

   always #50 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   // game-state source
   logic [8:0] pd [N_ENT];
   logic [3:0] pa [N_ENT];
   logic       pl [N_ENT];
   assign polar_distance = pd[polar_idx];
   assign polar_angle    = pa[polar_idx];
   assign polar_alive    = pl[polar_idx];

   // converter: cos*256 per 22.5 deg step, centre (399,239), y grows downward
   int cos_t [16] = '{256, 237, 181, 98, 0, -98, -181, -237,
                      -256, -237, -181, -98, 0, 98, 181, 237};

   function automatic logic [9:0] fx(input int d, input int a);
      int v;
      v = 399 + ((d * cos_t[a % 16]) >>> 8);
      return v[9:0];
   endfunction

   function automatic logic [9:0] fy(input int d, input int a);
      int v;
      v = 239 - ((d * cos_t[(a + 12) % 16]) >>> 8);
      return v[9:0];
   endfunction

   logic [9:0] px [LAT];
   logic [9:0] py [LAT];
   always @(posedge CLK) begin
      px[0] <= fx(int'(cv_distance), int'(cv_angle));
      py[0] <= fy(int'(cv_distance), int'(cv_angle));
      for (int i = 1; i < LAT; i++) begin
         px[i] <= px[i-1];
         py[i] <= py[i-1];
      end
   end
   assign cv_x = px[LAT-1];
   assign cv_y = py[LAT-1];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d",
                  nm, act, exp, cyc);
      end
   endtask

   // reference table: two banks, front selects what the renderer sees
   logic [9:0] mx [2][N_ENT];
   logic [9:0] my [2][N_ENT];
   logic       ma [2][N_ENT];
   int         mfront = 0;

   typedef struct {
      int                     cyc;
      logic [N_ENT*10-1:0]    x;
      logic [N_ENT*10-1:0]    y;
      logic [N_ENT-1:0]       a;
   } rec_t;

   rec_t dq [$];
   int   oq [$];
   int   req_n = 0;
   int   ack_n = 0;
   int   front_x0 = 0;

   task automatic model_clear();
      for (int b = 0; b < 2; b++)
         for (int i = 0; i < N_ENT; i++) begin
            mx[b][i] = '0;
            my[b][i] = '0;
            ma[b][i] = 1'b0;
         end
      mfront = 0;
   endtask

   task automatic sweep(input logic [N_ENT*10-1:0] ex,
                        input logic [N_ENT*10-1:0] ey,
                        input logic [N_ENT-1:0] ea, input string tag);
      for (int i = 0; i < N_ENT; i++) begin
         rd_idx = IDX_W'(i);
         #1;
         chk($sformatf("%s_x[%0d]", tag, i), rd_x, ex[i*10 +: 10]);
         chk($sformatf("%s_y[%0d]", tag, i), rd_y, ey[i*10 +: 10]);
         chk($sformatf("%s_alive[%0d]", tag, i), rd_alive, ea[i]);
      end
      rd_idx = '0;
   endtask

   // monitor: owns rd_idx, pops expectations on done/overrun
   initial begin
      rec_t                r;
      logic [N_ENT*10-1:0] ex;
      logic [N_ENT*10-1:0] ey;
      logic [N_ENT-1:0]    ea;
      rd_idx = '0;
      forever begin
         @(negedge CLK);
         if (RST) front_x0 = 0;
         if (done) begin
            if (dq.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL done_unexpected: got 1 expected 0 at cycle %0d",
                        cyc);
            end else begin
               r = dq.pop_front();
               chk("done_cycle", cyc, r.cyc);
               chk("done_busy", busy, 0);
               sweep(r.x, r.y, r.a, "scan");
               front_x0 = int'(r.x[9:0]);
            end
         end
`ifdef SHADOW_TABLE_EN
         else if (busy) chk("shadow_hold_x0", rd_x, front_x0);
`endif
         if (overrun) begin
            if (oq.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL overrun_unexpected: got 1 expected 0 at cycle %0d",
                        cyc);
            end else begin
               chk("overrun_cycle", cyc, oq.pop_front());
            end
         end
         if (req_n != ack_n) begin
            for (int i = 0; i < N_ENT; i++) begin
               ex[i*10 +: 10] = mx[mfront][i];
               ey[i*10 +: 10] = my[mfront][i];
               ea[i]          = ma[mfront][i];
            end
            chk("idle_busy", busy, 0);
            sweep(ex, ey, ea, "table");
            ack_n = req_n;
         end
      end
   end

   task automatic idle_hv();
      hc = 10'($urandom_range(1, 799));
      vc = 10'($urandom_range(0, 524));
   endtask

   task automatic request_sweep();
      req_n++;
      for (int k = 0; k < 5 && ack_n != req_n; k++) begin
         @(posedge CLK);
         #1;
      end
      if (ack_n != req_n) begin
         n_tests++;
         n_fail++;
         $display("FAIL sweep_timeout: got %0d expected %0d", ack_n, req_n);
         ack_n = req_n;
      end
   endtask

   // frame modes: 0 random, 1 all live random, 2 all dead
   task automatic set_frame(input int mode);
      for (int i = 0; i < N_ENT; i++) begin
         pd[i] = 9'($urandom_range(0, 511));
         pa[i] = 4'($urandom_range(0, 15));
         pl[i] = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      end
   endtask

   // called aligned at posedge+1 while the DUT is idle
   task automatic start_scan(output int t);
      rec_t r;
      int   cost;
      int   nb;
      cost = 0;
      nb   = SHADOW ? 1 - mfront : mfront;
      for (int i = 0; i < N_ENT; i++) begin
         if (pl[i]) begin
            mx[nb][i] = fx(int'(pd[i]), int'(pa[i]));
            my[nb][i] = fy(int'(pd[i]), int'(pa[i]));
            ma[nb][i] = 1'b1;
            cost += 2 + LAT;
         end else begin
            ma[nb][i] = 1'b0;
            cost += 1;
         end
      end
      mfront = nb;
      for (int i = 0; i < N_ENT; i++) begin
         r.x[i*10 +: 10] = mx[mfront][i];
         r.y[i*10 +: 10] = my[mfront][i];
         r.a[i]          = ma[mfront][i];
      end
      hc = 10'd0;
      vc = 10'(V_ACTIVE);
      @(posedge CLK);
      #1;
      t = cyc;
      idle_hv();
      r.cyc = t + cost;
      dq.push_back(r);
   endtask

   task automatic wait_done();
      for (int k = 0; k < 300 && dq.size() != 0; k++) begin
         @(posedge CLK);
         #1;
      end
      if (dq.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL scan_timeout: got %0d pending expected 0", dq.size());
         dq.delete();
      end
      repeat (2) @(posedge CLK);
      #1;
   endtask

   initial begin
      int t;
      model_clear();
      set_frame(2);
      repeat (3) @(posedge CLK);
      #1;
      RST = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_cv_distance", cv_distance, 0);
      chk("rst_cv_angle", cv_angle, 0);
      chk("rst_polar_idx", polar_idx, 0);
      request_sweep();

      // single live slot
      set_frame(2);
      pl[0] = 1'b1;
      pd[0] = 9'd100;
      pa[0] = 4'd0;
      start_scan(t);
      chk("busy_rise", busy, 1);
      @(posedge CLK);
      #1;
      chk("cv_distance_ld", cv_distance, 100);
      chk("cv_angle_ld", cv_angle, 0);
      wait_done();
      chk("cv_hold_idle", cv_distance, 100);

      // all live, distance 10k, angle 90 deg
      for (int i = 0; i < N_ENT; i++) begin
         pl[i] = 1'b1;
         pd[i] = 9'(10 * i);
         pa[i] = 4'd4;
      end
      start_scan(t);
      wait_done();

      // slot 3 dies between frames
      set_frame(1);
      start_scan(t);
      wait_done();
      pl[3] = 1'b0;
      start_scan(t);
      wait_done();

      // second trigger 5 cycles into a scan
      set_frame(1);
      start_scan(t);
      repeat (4) @(posedge CLK);
      #1;
      hc = 10'd0;
      vc = 10'(V_ACTIVE);
      @(posedge CLK);
      #1;
      oq.push_back(cyc);
      idle_hv();
      wait_done();

      // reset 6 cycles into a scan
      set_frame(1);
      start_scan(t);
      repeat (5) @(posedge CLK);
      #1;
      RST = 1'b1;
      @(posedge CLK);
      #1;
      RST = 1'b0;
      dq.delete();
      model_clear();
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      request_sweep();
      repeat (30) @(posedge CLK);
      #1;
      set_frame(1);
      start_scan(t);
      wait_done();

      // random frames
      for (int f = 0; f < 8; f++) begin
         set_frame(0);
         start_scan(t);
         wait_done();
      end

      chk("done_queue_empty", dq.size(), 0);
      chk("overrun_queue_empty", oq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/entity_coord_scheduler.md
Name: entity_coord_scheduler

Overview:
- Time-shares one polar-to-screen coordinate converter among N_ENT entity slots.
- Once per frame, at the start of vertical blanking, it walks every slot and reads that slot's distance and angle from the game-state source.
- For each live slot it drives the shared converter, waits the converter latency and latches the resulting screen x/y into a coordinate table.
- The renderer reads that table during active video.

Parameters:
- N_ENT, 8, number of entity slots (power of 2, 2..16).
- IDX_W, 3, slot index width, equal to log2(N_ENT).
- LAT, 1, converter latency in cycles from stable inputs to valid x/y (1..4).
- V_ACTIVE, 480, vc value at which the scan is triggered.

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- RST  in  1  synchronous, active-high reset.
- hc  in  10  horizontal pixel counter.
- vc  in  10  vertical line counter.
- polar_idx  out  IDX_W  slot currently addressed on the polar source.
- polar_distance  in  9  distance of the addressed slot; combinational, valid in the same cycle.
- polar_angle  in  4  angle code of the addressed slot (16 steps of 22.5 deg).
- polar_alive  in  1  addressed slot is active.
- cv_distance  out  9  registered distance to the converter.
- cv_angle  out  4  registered angle to the converter.
- cv_x  in  10  converter x result.
- cv_y  in  10  converter y result.
- rd_idx  in  IDX_W  renderer read address.
- rd_x  out  10  table x for rd_idx; combinational read.
- rd_y  out  10  table y for rd_idx; combinational read.
- rd_alive  out  1  table alive flag for rd_idx.
- busy  out  1  high while the scan is in progress.
- done  out  1  one-cycle pulse when the last slot has been processed.
- overrun  out  1  one-cycle pulse when a trigger arrives while busy.

Behaviour:
- Trigger: trig = (hc == 0 && vc == V_ACTIVE), evaluated every cycle.
- Reset (RST = 1 at posedge):
  - state goes to IDLE; slot counter = 0.
  - cv_distance = 0, cv_angle = 0.
  - busy = 0, done = 0, overrun = 0, polar_idx = 0.
  - All table entries: x = 0, y = 0, alive = 0.
  - Reset asserted mid-scan aborts the scan immediately; no partial writes are made after reset.
- States:
  - IDLE:
    - busy = 0.
    - On trig: slot = 0, go to ISSUE.
  - ISSUE:
    - busy = 1; polar_idx = slot.
    - If polar_alive: register cv_distance <= polar_distance and cv_angle <= polar_angle, clear wait counter, go to WAIT.
    - Otherwise: write alive[slot] = 0, leave x/y unchanged, go to ADV.
  - WAIT:
    - Hold cv_* stable.
    - Stay exactly LAT cycles, then go to STORE.
  - STORE:
    - Write x[slot] = cv_x, y[slot] = cv_y, alive[slot] = 1.
    - Go to ADV.
  - ADV (combinational decision, no extra cycle; taken in the same edge as the ISSUE-dead or STORE write):
    - If slot == N_ENT-1: done = 1 for one cycle, go to IDLE.
    - Otherwise: slot++, go to ISSUE.
- Cycle cost:
  - Live slot: 1 (ISSUE) + LAT (WAIT) + 1 (STORE).
  - Dead slot: 1 cycle.
  - Full scan, all live, LAT = 1: 24 cycles.
- done timing: done asserts in the cycle after the final table write, while state is IDLE.
- busy: deasserts in that same cycle.
- Trigger while not IDLE:
  - The trigger is ignored and the scan continues.
  - overrun pulses for 1 cycle.
- Trigger in the same cycle done is high: state is already IDLE, so the trigger is accepted normally.
- cv_* hold their last values while IDLE.
- No arithmetic is performed here; x/y values are stored verbatim from the converter, including any converter wrap-around.

Optional Feature:
- Macro: SHADOW_TABLE_EN.
- Defined:
  - Two table banks.
  - The scan writes the back bank; rd_* read the front bank.
  - On the done cycle the banks swap, so rd_* change only at frame boundaries.
  - The back bank is first initialised by copying nothing: each scan rewrites every alive flag, and x/y are preserved per bank.
  - Reset clears both banks.
- Undefined:
  - Single bank written in place.
  - rd_* reflect each entry immediately after its write, so entries may be mixed between frames during a scan.

Test Plan:
- Reset -> all rd_* = 0 for every rd_idx; busy = 0, done = 0, overrun = 0; cv_distance = 0.
- Slot0 live, distance 100, angle 0, converter model LAT = 1; others dead; drive hc = 0, vc = 480 -> busy rises; cv_distance = 100, cv_angle = 0 one cycle after trigger; rd_x[0] = 499, rd_y[0] = 239, rd_alive[0] = 1; scan length 3 + 7 = 10 cycles; done pulses once.
- All 8 slots live, slot k has distance 10*k and angle 4 -> 24-cycle scan; rd_y[k] = 239 - 10*k; rd_x[k] = 399 for every k.
- Slot3 alive in frame 1 and dead in frame 2 -> rd_alive[3] = 0 after frame 2; rd_x[3] and rd_y[3] retain their frame-1 values.
- Second trigger 5 cycles into a scan -> overrun = 1 for exactly 1 cycle; the scan completes at its original cycle count; no restart.
- RST asserted 6 cycles into a scan -> IDLE and table cleared next cycle; no done pulse; a new trigger then runs a full scan normally.
- With SHADOW_TABLE_EN defined: rd_x[0] keeps its old value throughout a scan and changes to the new value exactly on the done cycle.
